l2_line_fill: RTL and testbench

Line-fill engine for the L2 cache.
- On a miss, the L2 controller issues a fill request with the target set index.
- The engine reads one line from physical memory as a sequence of narrow beats and assembles the beats into a full line buffer.
- It then performs a single write into the L2 data array: it drives the array's write, index and datain inputs.
- It sits between the L2 control FSM, the physical-memory port and the 16-entry, 128-bit L2 data array.

---
 rtl/l2_line_fill.sv | 133 +++++++++++++
 tb/tb_l2_line_fill.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_fill.sv
// L2 line-fill engine: fetches BEATS narrow memory beats, assembles a line, writes it once.
// Optional FETCH idle timeout compiled in with L2_FILL_TIMEOUT_EN.
module l2_line_fill #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned BEAT_WIDTH = 32,
  parameter int unsigned INDEX_W    = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fill_req,
  input  logic [INDEX_W-1:0]    fill_index,
  output logic                  fill_ready,
  output logic                  fill_done,
  output logic                  fill_err,
  output logic                  mem_read,
  input  logic                  mem_resp,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  output logic                  array_write,
  output logic [INDEX_W-1:0]    array_index,
  output logic [WIDTH-1:0]      array_datain
);

  localparam int unsigned   BEATS     = WIDTH / BEAT_WIDTH;
  localparam int unsigned   BW        = $clog2(BEATS);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [WIDTH-1:0]   line_q, line_d;
  logic               mem_read_q;
  logic               done_q;

`ifdef L2_FILL_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign fill_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign fill_err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    line_d  = line_q;
`ifdef L2_FILL_TIMEOUT_EN
    to_d    = to_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fill_req) begin
          idx_d   = fill_index;
          beat_d  = '0;
          line_d  = '0;
          state_d = FETCH;
`ifdef L2_FILL_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      FETCH: begin
        if (mem_resp) begin
          // Constant-offset slices per beat slot keep the select static.
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_LAST) state_d = WRITE;
        end
`ifdef L2_FILL_TIMEOUT_EN
        // A beat landing on the limit cycle wins over the abort.
        if (mem_resp) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      mem_read_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      mem_read_q <= (state_d == FETCH);
      done_q     <= (state_d == WRITE);
    end
  end

  assign fill_ready   = (state_q == IDLE);
  assign fill_done    = done_q;
  assign array_write  = done_q;
  assign mem_read     = mem_read_q;
  assign array_index  = idx_q;
  assign array_datain = line_q;

endmodule

// File: tb/tb_l2_line_fill.sv
// Directed bench for l2_line_fill: table of fills plus hand-written reset, idle-resp and timeout sequences.
module tb_l2_line_fill;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         fill_req;
  logic [3:0]   fill_index;
  logic         fill_ready, fill_done, fill_err, mem_read;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         array_write;
  logic [3:0]   array_index;
  logic [127:0] array_datain;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned wr_cnt  = 0;
  int unsigned err_cnt = 0;

  l2_line_fill #(
    .WIDTH      (128),
    .BEAT_WIDTH (32),
    .INDEX_W    (4),
    .TIMEOUT    (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fill_req     (fill_req),
    .fill_index   (fill_index),
    .fill_ready   (fill_ready),
    .fill_done    (fill_done),
    .fill_err     (fill_err),
    .mem_read     (mem_read),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .array_write  (array_write),
    .array_index  (array_index),
    .array_datain (array_datain)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (array_write === 1'b1) wr_cnt++;
    if (fill_err === 1'b1) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]   idx;
    logic [31:0]  b [4];
    int unsigned  gap;
    bit           poke;
    bit           resp_wr;
    logic [127:0] exp_line;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Entered and left at #1 after an edge with the DUT in IDLE.
  task automatic run_fill(input string nm, input logic [3:0] idx, input logic [31:0] b [4],
                          input int unsigned g [4], input bit poke, input bit resp_wr,
                          input logic [127:0] exp_line);
    int unsigned w0;
    int unsigned bad;
    w0  = wr_cnt;
    bad = 0;
    chk({nm, "_ready_idle"}, 128'(fill_ready), 128'd1);
    fill_req   = 1'b1;
    fill_index = idx;
    tick();
    fill_req   = poke;
    fill_index = 4'hA;
    chk({nm, "_mem_read_t1"}, 128'(mem_read), 128'd1);
    for (int k = 0; k < 4; k++) begin
      for (int unsigned j = 0; j < g[k]; j++) begin
        mem_resp = 1'b0;
        if (mem_read !== 1'b1) bad++;
        tick();
      end
      mem_resp  = 1'b1;
      mem_rdata = b[k];
      if (mem_read !== 1'b1) bad++;
      tick();
    end
    fill_req  = 1'b0;
    mem_resp  = resp_wr;
    mem_rdata = 32'hBADBAD00;
    chk({nm, "_mem_read_held"}, 128'(bad), 128'd0);
    chk({nm, "_write"},    128'(array_write), 128'd1);
    chk({nm, "_done"},     128'(fill_done),   128'd1);
    chk({nm, "_index"},    128'(array_index), 128'(idx));
    chk({nm, "_datain"},   array_datain,      exp_line);
    chk({nm, "_rd_low_w"}, 128'(mem_read),    128'd0);
    chk({nm, "_busy_w"},   128'(fill_ready),  128'd0);
    tick();
    mem_resp = 1'b0;
    chk({nm, "_ready_back"}, 128'(fill_ready), 128'd1);
    chk({nm, "_write_off"},  128'(array_write), 128'd0);
    chk({nm, "_one_write"},  128'(wr_cnt - w0), 128'd1);
    chk({nm, "_line_kept"},  array_datain, exp_line);
  endtask

  initial begin
    logic [31:0]  bb [4];
    int unsigned  gg [4];
    int unsigned  w0;
    int unsigned  n;

    vecs[0] = '{idx: 4'h5, b: '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                gap: 0, poke: 0, resp_wr: 0,
                exp_line: 128'h44444444_33333333_22222222_11111111};
    vecs[1] = '{idx: 4'h5, b: '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                gap: 3, poke: 0, resp_wr: 0,
                exp_line: 128'h44444444_33333333_22222222_11111111};
    vecs[2] = '{idx: 4'h7, b: '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D},
                gap: 1, poke: 1, resp_wr: 1,
                exp_line: 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF};
    vecs[3] = '{idx: 4'hF, b: '{32'h00000000, 32'h00000000, 32'h00000000, 32'h80000001},
                gap: 2, poke: 1, resp_wr: 0,
                exp_line: 128'h80000001_00000000_00000000_00000000};
    vecs[4] = '{idx: 4'h0, b: '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0},
                gap: 0, poke: 0, resp_wr: 1,
                exp_line: 128'hF0F0F0F0_0F0F0F0F_5A5A5A5A_A5A5A5A5};

    reset_n    = 1'b0;
    fill_req   = 1'b0;
    fill_index = '0;
    mem_resp   = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    chk("rst_ready",  128'(fill_ready),  128'd1);
    chk("rst_done",   128'(fill_done),   128'd0);
    chk("rst_err",    128'(fill_err),    128'd0);
    chk("rst_mem_rd", 128'(mem_read),    128'd0);
    chk("rst_write",  128'(array_write), 128'd0);
    chk("rst_index",  128'(array_index), 128'd0);
    chk("rst_datain", array_datain,      128'd0);
    reset_n = 1'b1;
    tick();

    // Fills are chained so each request lands in the cycle ready returns.
    for (int i = 0; i < 5; i++) begin
      gg = '{0, vecs[i].gap, vecs[i].gap, vecs[i].gap};
      run_fill($sformatf("vec%0d", i), vecs[i].idx, vecs[i].b, gg,
               vecs[i].poke, vecs[i].resp_wr, vecs[i].exp_line);
    end

    // mem_resp while idle must not start or disturb anything.
    w0 = wr_cnt;
    mem_resp  = 1'b1;
    mem_rdata = 32'h13579BDF;
    tick();
    tick();
    tick();
    mem_resp = 1'b0;
    chk("idle_resp_ready",  128'(fill_ready), 128'd1);
    chk("idle_resp_rd",     128'(mem_read),   128'd0);
    chk("idle_resp_nowr",   128'(wr_cnt - w0), 128'd0);
    chk("idle_resp_datain", array_datain, 128'hF0F0F0F0_0F0F0F0F_5A5A5A5A_A5A5A5A5);

    // Reset in the middle of FETCH after two beats.
    w0 = wr_cnt;
    fill_req   = 1'b1;
    fill_index = 4'h9;
    tick();
    fill_req  = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rdata = 32'h12345678;
    tick();
    mem_resp = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("mrst_ready",  128'(fill_ready),  128'd1);
    chk("mrst_done",   128'(fill_done),   128'd0);
    chk("mrst_err",    128'(fill_err),    128'd0);
    chk("mrst_mem_rd", 128'(mem_read),    128'd0);
    chk("mrst_write",  128'(array_write), 128'd0);
    chk("mrst_index",  128'(array_index), 128'd0);
    chk("mrst_datain", array_datain,      128'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("mrst_nowr", 128'(wr_cnt - w0), 128'd0);
    bb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    gg = '{0, 0, 0, 0};
    run_fill("after_rst", 4'h3, bb, gg, 1'b0, 1'b0, {128{1'b1}});

`ifdef L2_FILL_TIMEOUT_EN
    // Two beats then silence: abort after 8 idle cycles.
    w0 = wr_cnt;
    fill_req   = 1'b1;
    fill_index = 4'h6;
    tick();
    fill_req  = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 32'hAAAA0001;
    tick();
    mem_rdata = 32'hAAAA0002;
    tick();
    mem_resp = 1'b0;
    n = 1;
    while (fill_err !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("to_err_cycle", 128'(n),           128'd9);
    chk("to_rd_drop",   128'(mem_read),    128'd0);
    chk("to_ready",     128'(fill_ready),  128'd1);
    chk("to_nowr",      128'(wr_cnt - w0), 128'd0);
    tick();
    chk("to_err_pulse", 128'(fill_err),    128'd0);
    chk("to_err_once",  128'(err_cnt),     128'd1);

    bb = '{32'hB0000000, 32'hB1111111, 32'hB2222222, 32'hB3333333};
    gg = '{0, 0, 7, 0};
    run_fill("to_edge", 4'hC, bb, gg, 1'b0, 1'b0, 128'hB3333333_B2222222_B1111111_B0000000);
    chk("to_edge_noerr", 128'(err_cnt), 128'd1);
`else
    bb = '{32'hC0000000, 32'hC1111111, 32'hC2222222, 32'hC3333333};
    gg = '{0, 0, 40, 0};
    run_fill("no_timeout", 4'hC, bb, gg, 1'b0, 1'b0, 128'hC3333333_C2222222_C1111111_C0000000);
    chk("no_timeout_err", 128'(err_cnt), 128'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
